// File: rtl/sobel_window_gen_pkg.sv
// Shared types for the Sobel window generator: pixel and 3x3 window layouts
// and the frame-level state encoding.
package sobel_pkg;

  localparam int KERNEL_DIM = 3;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [KERNEL_DIM-1:0][KERNEL_DIM-1:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } win_state_t;

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out stream bundle; master is the window generator side,
// slave is the fetch + Sobel environment around it.
interface sobel_window_gen_if;
  import sobel_pkg::*;

  pixel_t  pix_in;
  logic    pix_valid;
  logic    pix_ready;
  window_t comp_matrix;
  logic    sobel_en;
  logic    win_ready;

  modport master (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, comp_matrix, sobel_en
  );

  modport slave (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, comp_matrix, sobel_en
  );

endinterface

// File: rtl/sobel_window_gen_line_buffer.sv
// Two-row line buffer: column i_idx returns the pixels one and two rows above,
// and on shift the older row takes the newer and the newer takes i_pix.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_shift,
  input  logic [AW-1:0] i_idx,
  input  pixel_t        i_pix,
  output pixel_t        o_lb1,
  output pixel_t        o_lb0
);

  pixel_t r_lb0 [0:DEPTH-1];
  pixel_t r_lb1 [0:DEPTH-1];

  assign o_lb1 = r_lb1[i_idx];
  assign o_lb0 = r_lb0[i_idx];

  // Storage only; every column is rewritten before it is read in a frame.
  always_ff @(posedge clk) begin
    if (i_shift) begin
      r_lb1[i_idx] <= r_lb0[i_idx];
      r_lb0[i_idx] <= i_pix;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator feeding the Sobel core: buffers two rows and
// presents each interior neighbourhood as a registered window with handshake.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  sobel_window_gen_if.master  bus,
  output logic                frame_done,
  output logic                busy
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(KERNEL_DIM - 1);
  localparam logic [RW-1:0] R_MIN  = RW'(KERNEL_DIM - 1);

  win_state_t    r_state;
  win_state_t    w_state_nxt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  window_t       r_win_p1;
  logic          vld_p1;
  logic          r_last_p1;

  logic   w_accept;
  logic   w_consume;
  logic   w_win_pos;
  logic   w_pix_ready;
  logic   w_frame_done;
  logic   w_busy;
  logic   w_arm;
  pixel_t w_lb1;
  pixel_t w_lb0;

  assign w_consume = vld_p1 && bus.win_ready;
  assign w_accept  = bus.pix_valid && w_pix_ready;
  assign w_win_pos = (r_row >= R_MIN) && (r_col >= C_MIN);

  sobel_line_buffer #(
    .DEPTH (IMG_WIDTH)
  ) u_line_buffer (
    .clk     (clk),
    .i_shift (w_accept),
    .i_idx   (r_col),
    .i_pix   (bus.pix_in),
    .o_lb1   (w_lb1),
    .o_lb0   (w_lb0)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pix_ready  = 1'b0;
    w_frame_done = 1'b0;
    w_busy       = 1'b0;
    w_arm        = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (frame_start) begin
          w_state_nxt = ACTIVE;
          w_arm       = 1'b1;
        end
      end
      ACTIVE: begin
        w_busy      = 1'b1;
        w_pix_ready = !vld_p1 || bus.win_ready;
        if (w_consume && r_last_p1) begin
          w_state_nxt  = DONE;
          w_frame_done = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: accepted pixel plus line-buffer column shift into the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_win_p1  <= '0;
      vld_p1    <= 1'b0;
      r_last_p1 <= 1'b0;
    end else if (w_arm) begin
      r_col     <= '0;
      r_row     <= '0;
      vld_p1    <= 1'b0;
      r_last_p1 <= 1'b0;
    end else if (w_accept) begin
      for (int i = 0; i < KERNEL_DIM; i++) begin
        r_win_p1[i][0] <= r_win_p1[i][1];
        r_win_p1[i][1] <= r_win_p1[i][2];
      end
      r_win_p1[0][2] <= w_lb1;
      r_win_p1[1][2] <= w_lb0;
      r_win_p1[2][2] <= bus.pix_in;
      // Needing c>=2 flushes the previous row's columns after a wrap.
      vld_p1 <= w_win_pos;
      if (r_col == C_LAST) begin
        r_col <= '0;
        if (r_row == R_LAST) begin
          r_row     <= '0;
          r_last_p1 <= 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end else if (w_consume) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.pix_ready   = w_pix_ready;
  assign bus.comp_matrix = r_win_p1;
  assign bus.sobel_en    = vld_p1;
  assign frame_done      = w_frame_done;
  assign busy            = w_busy;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 4x4 image: expected windows are
// queued as pixels are accepted and compared when the window is consumed.
module tb_sobel_window_gen;
  import sobel_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic clk;
  logic rst;
  logic frame_start;
  logic frame_done;
  logic busy;

  sobel_window_gen_if bus ();

  sobel_window_gen #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bus         (bus.master),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  int      total;
  int      bad;
  pixel_t  img [0:H-1][0:W-1];
  window_t exp_q [$];

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    total++; if (bus.sobel_en !== 1'b0) begin bad++; $display("FAIL rst_sobel_en got=%0b exp=0", bus.sobel_en); end
    total++; if (bus.comp_matrix !== '0) begin bad++; $display("FAIL rst_comp_matrix got=%h exp=0", bus.comp_matrix); end
    total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL rst_pix_ready got=%0b exp=0", bus.pix_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%0b exp=0", frame_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_idle();
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'h5a;
    bus.win_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL idle_pix_ready got=%0b exp=0", bus.pix_ready); end
      total++; if (bus.sobel_en !== 1'b0) begin bad++; $display("FAIL idle_sobel_en got=%0b exp=0", bus.sobel_en); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    end
    bus.pix_valid = 1'b0;
  endtask

  // One full frame; inv selects 255-p data, bp stalls the first window, mid pulses frame_start mid-frame.
  task automatic test_frame(input bit inv, input int bp, input bit mid, input string nm);
    int br, bc, sent, nwin, ndone, hold, cyc;
    bit mvld, active, fin, vin, rdy, acc, cons, exp_rdy, exp_done, mid_done, pos;
    window_t w;
    br = 0; bc = 0; sent = 0; nwin = 0; ndone = 0; hold = 0; cyc = 0;
    mvld = 1'b0; active = 1'b1; fin = 1'b0; mid_done = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = inv ? pixel_t'(255 - (W * r + c)) : pixel_t'(W * r + c);
    exp_q.delete();
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b1;
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s start_busy got=%0b exp=1", nm, busy); end
    while (!fin && cyc < 300) begin
      cyc++;
      vin = (sent < NPIX);
      bus.pix_valid = vin;
      bus.pix_in    = vin ? img[br][bc] : 8'h00;
      rdy = 1'b1;
      if (mvld && nwin == 0 && hold < bp) begin
        rdy = 1'b0;
        hold++;
      end
      bus.win_ready = rdy;
      frame_start = mid && sent == 7 && !mid_done;
      if (frame_start) mid_done = 1'b1;
      #1;
      exp_rdy  = active && (!mvld || rdy);
      cons     = mvld && rdy;
      exp_done = cons && (nwin == NWIN - 1);
      total++; if (bus.sobel_en !== mvld) begin bad++; $display("FAIL %s sobel_en px=%0d got=%0b exp=%0b", nm, sent, bus.sobel_en, mvld); end
      total++; if (bus.pix_ready !== exp_rdy) begin bad++; $display("FAIL %s pix_ready px=%0d got=%0b exp=%0b", nm, sent, bus.pix_ready, exp_rdy); end
      total++; if (frame_done !== exp_done) begin bad++; $display("FAIL %s frame_done px=%0d got=%0b exp=%0b", nm, sent, frame_done, exp_done); end
      if (mvld && !rdy && exp_q.size() > 0) begin
        total++; if (bus.comp_matrix !== exp_q[0]) begin bad++; $display("FAIL %s hold_window got=%h exp=%h", nm, bus.comp_matrix, exp_q[0]); end
      end
      if (cons) begin
        if (exp_q.size() == 0) begin
          total++; bad++; $display("FAIL %s window_underflow got=%h exp=none", nm, bus.comp_matrix);
        end else begin
          w = exp_q.pop_front();
          total++; if (bus.comp_matrix !== w) begin bad++; $display("FAIL %s window%0d got=%h exp=%h", nm, nwin, bus.comp_matrix, w); end
        end
        nwin++;
        if (exp_done) begin ndone++; active = 1'b0; end
      end
      acc = vin && exp_rdy;
      pos = (br >= 2) && (bc >= 2);
      if (acc) begin
        if (pos) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              w[i][j] = img[br - 2 + i][bc - 2 + j];
          exp_q.push_back(w);
        end
        sent++;
        if (bc == W - 1) begin bc = 0; br++; end
        else bc++;
        mvld = pos;
      end else if (cons) begin
        mvld = 1'b0;
      end
      fin = (sent == NPIX) && !mvld && exp_q.size() == 0;
      cycle();
    end
    frame_start   = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_in    = 8'h77;
    #1;
    total++; if (!fin) begin bad++; $display("FAIL %s timeout got=%0d_windows exp=%0d", nm, nwin, NWIN); end
    total++; if (nwin !== NWIN) begin bad++; $display("FAIL %s window_count got=%0d exp=%0d", nm, nwin, NWIN); end
    total++; if (ndone !== 1) begin bad++; $display("FAIL %s done_pulses got=%0d exp=1", nm, ndone); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s done_busy got=%0b exp=0", nm, busy); end
    total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL %s done_pix_ready got=%0b exp=0", nm, bus.pix_ready); end
    cycle();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL %s done_repeat got=%0b exp=0", nm, frame_done); end
    total++; if (bus.sobel_en !== 1'b0) begin bad++; $display("FAIL %s done_sobel_en got=%0b exp=0", nm, bus.sobel_en); end
    bus.pix_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, cyc;
    k = 0; cyc = 0;
    bus.win_ready = 1'b1;
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    while (k < 13 && cyc < 100) begin
      cyc++;
      bus.pix_valid = 1'b1;
      bus.pix_in    = pixel_t'(k);
      #1;
      if (bus.pix_ready) k++;
      cycle();
    end
    total++; if (k != 13) begin bad++; $display("FAIL rstmid_feed got=%0d exp=13", k); end
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_done_in_rst got=%0b exp=0", frame_done); end
    cycle();
    rst = 1'b0;
    #1;
    total++; if (bus.sobel_en !== 1'b0) begin bad++; $display("FAIL rstmid_sobel_en got=%0b exp=0", bus.sobel_en); end
    total++; if (bus.comp_matrix !== '0) begin bad++; $display("FAIL rstmid_comp_matrix got=%h exp=0", bus.comp_matrix); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    bus.pix_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      cycle();
      total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL rstmid_pix_ready got=%0b exp=0", bus.pix_ready); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rstmid_frame_done got=%0b exp=0", frame_done); end
    end
    bus.pix_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst   = 1'b1;
    frame_start   = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = 8'h00;
    bus.win_ready = 1'b0;
    test_reset();
    test_idle();
    test_frame(1'b0, 0, 1'b0, "stream");
    test_frame(1'b1, 0, 1'b0, "back_to_back");
    test_frame(1'b0, 5, 1'b1, "backpressure");
    test_reset_mid();
    test_frame(1'b1, 0, 1'b0, "after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
